// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port.
// Lane-shift helper maps (size, byte offset) to the bit position of the selected lane.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned SHIFT_W = 5;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    ST_WR   = 3'd3,
    RESP    = 3'd4
  } lsu_state_e;

  // Request attributes captured at accept
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [LANE_W-1:0] off;
    logic [WORD_W-1:0] wdata;
  } lsu_req_t;

  // Words always use lane 0; halves ignore the low offset bit
  function automatic logic [SHIFT_W-1:0] lane_shift(input logic [1:0] size,
                                                    input logic [LANE_W-1:0] off);
    case (size)
      SZ_B:    return {off, 3'b000};
      SZ_H:    return {off[1], 4'b0000};
      default: return SHIFT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response and memory-bus bundle for lsu_mem_port.
// slave is the LSU side; master is the execute stage plus attached memory.
interface lsu_mem_port_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_err;
  logic [WORD_W-1:0] resp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane extract with sign/zero extension, and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [LANE_W-1:0] i_off,
  input  logic              i_unsigned,
  input  logic [WORD_W-1:0] i_rdata,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_load_c,
  output logic [WORD_W-1:0] o_merge_c
);

  logic [SHIFT_W-1:0] w_shift;
  logic [WORD_W-1:0]  w_shr;
  logic [WORD_W-1:0]  w_mask;

  assign w_shift = lane_shift(i_size, i_off);
  assign w_shr   = i_rdata >> w_shift;

  always_comb begin
    o_load_c = i_rdata;
    w_mask   = '1;
    case (i_size)
      SZ_B: begin
        w_mask   = WORD_W'({BYTE_W{1'b1}}) << w_shift;
        o_load_c = i_unsigned ? WORD_W'(w_shr[BYTE_W-1:0])
                              : {{(WORD_W-BYTE_W){w_shr[BYTE_W-1]}}, w_shr[BYTE_W-1:0]};
      end
      SZ_H: begin
        w_mask   = WORD_W'({HALF_W{1'b1}}) << w_shift;
        o_load_c = i_unsigned ? WORD_W'(w_shr[HALF_W-1:0])
                              : {{(WORD_W-HALF_W){w_shr[HALF_W-1]}}, w_shr[HALF_W-1:0]};
      end
      default: ;
    endcase
  end

  // Only the selected lane takes store data; other bytes come from the read word
  assign o_merge_c = (i_rdata & ~w_mask) | ((i_wdata << w_shift) & w_mask);

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a single-port synchronous word memory; sub-word stores are RMW.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_port_if.slave  bus
);

  lsu_state_e        r_state;
  lsu_req_t          r_req;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [WORD_W-1:0] r_resp_rdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;

  logic              w_accept;
  logic              w_err;
  logic              w_oor;
  logic              w_bad_size;
  logic              w_misalign;
  logic              w_word_store;
  logic [ADDR_W-1:0] w_word_idx;
  logic [WORD_W-1:0] w_load;
  logic [WORD_W-1:0] w_merge;

  assign w_accept     = bus.req_valid && r_req_ready;
  assign w_word_idx   = {2'b00, bus.req_addr[ADDR_W-1:2]};
  assign w_oor        = w_word_idx >= ADDR_W'(DEPTH);
  assign w_bad_size   = bus.req_size == SZ_X;
  assign w_word_store = bus.req_we && (bus.req_size == SZ_W);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                      ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_bad_size || w_oor || w_misalign;

  lsu_align u_align (
    .i_size     (r_req.size),
    .i_off      (r_req.off),
    .i_unsigned (r_req.uns),
    .i_rdata    (bus.mem_rdata),
    .i_wdata    (r_req.wdata),
    .o_load_c   (w_load),
    .o_merge_c  (w_merge)
  );

  // Sequencer: every output is registered and set for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.we    <= bus.req_we;
            r_req.size  <= bus.req_size;
            r_req.uns   <= bus.req_unsigned;
            r_req.off   <= bus.req_addr[LANE_W-1:0];
            r_req.wdata <= bus.req_wdata;
            r_mem_addr  <= w_word_idx;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (w_word_store) begin
              r_state     <= ST_WR;
              r_mem_wr    <= 1'b1;
              r_mem_wdata <= bus.req_wdata;
            end else begin
              r_state  <= RD;
              r_mem_rd <= 1'b1;
            end
          end
        end
        RD: begin
          r_state  <= RD_WAIT;
          r_mem_rd <= 1'b0;
        end
        RD_WAIT: begin
          if (r_req.we) begin
            r_state     <= ST_WR;
            r_mem_wr    <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load;
          end
        end
        ST_WR: begin
          r_state      <= RESP;
          r_mem_wr     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        RESP: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_mem_rd     <= 1'b0;
          r_mem_wr     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
